// File: rtl/spi_master_ctrl.sv
// SPI command master: serialises 10-bit RAM commands on SS_n/MOSI and captures 8-bit read replies from MISO.
// Optional frame counter output enabled by `define SPI_MASTER_CNT_EN.
module spi_master_ctrl #(
  parameter int CMD_W    = 10,
  parameter int DATA_W   = 8,
  parameter int RD_TURN  = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
`ifdef SPI_MASTER_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int MAX_A   = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int MAX_B   = (RD_TURN > IDLE_GAP) ? RD_TURN : IDLE_GAP;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SHIFT, S_TURN, S_RECV, S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CMD_W-1:0]    r_cmd_q;
  logic [DATA_W-2:0]   r_shift;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_vld;
  logic                w_accept;
  logic                w_cnt_zero;
  logic                w_rd_data;

  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_rd_data  = (r_cmd_q[CMD_W-1 -: 2] == 2'b11);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_next = S_START;
      S_START: w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_cnt_zero) begin
          if (w_rd_data) begin
            w_next = (RD_TURN == 0) ? S_RECV : S_TURN;
          end else begin
            w_next = S_GAP;
          end
        end
      end
      S_TURN:  if (w_cnt_zero) w_next = S_RECV;
      S_RECV:  if (w_cnt_zero) w_next = S_GAP;
      S_GAP:   if (w_cnt_zero) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    SS_n = 1'b1;
    MOSI = 1'b0;
    case (r_state)
      S_START: begin
        SS_n = 1'b0;
        MOSI = r_cmd_q[CMD_W-1];
      end
      S_SHIFT: begin
        SS_n = 1'b0;
        MOSI = r_cmd_q[r_cnt];
      end
      S_TURN, S_RECV: SS_n = 1'b0;
      default: ;
    endcase
  end

  // One shared down-counter, reloaded with the phase length on every state change; holds at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      case (w_next)
        S_SHIFT: r_cnt <= CNT_W'(CMD_W - 1);
        S_TURN:  r_cnt <= CNT_W'(RD_TURN - 1);
        S_RECV:  r_cnt <= CNT_W'(DATA_W - 1);
        S_GAP:   r_cnt <= CNT_W'(IDLE_GAP - 1);
        default: r_cnt <= '0;
      endcase
    end else if (!w_cnt_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_q    <= '0;
      r_shift    <= '0;
      r_rsp_data <= '0;
      r_rsp_vld  <= 1'b0;
    end else begin
      r_rsp_vld <= 1'b0;
      if (w_accept) begin
        r_cmd_q <= cmd_data;
      end
      if (r_state == S_RECV) begin
        r_shift <= {r_shift[DATA_W-3:0], MISO};
        if (w_cnt_zero) begin
          r_rsp_data <= {r_shift, MISO};
          r_rsp_vld  <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = r_rsp_vld;
  assign rsp_data  = r_rsp_data;

`ifdef SPI_MASTER_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if ((w_next == S_GAP) && (r_state != S_GAP)) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: frame shape, read capture, back-to-back commands, mid-frame reset.
module tb_spi_master_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
`ifdef SPI_MASTER_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  spi_master_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
`ifdef SPI_MASTER_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          f_low;
  int          f_rsp_at;
  int          f_rsp_n;
  int          f_rdy_bad;
  int          f_gap;
  logic [31:0] f_mosi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command, plays slave for the RECV window (bits 13..20 after SS_n fall),
  // drives MISO=1 elsewhere, optionally asserts rst at frame cycle rst_at.
  task automatic run_frame(input logic [9:0] cmd, input logic [7:0] rx, input int rst_at);
    int k;
    bit done;
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    tick();
    cmd_valid = 1'b0;
    f_mosi = '0; f_rsp_at = -1; f_rsp_n = 0; f_rdy_bad = 0; f_gap = 0;
    k = 0;
    done = 1'b0;
    while (!done) begin
      if (SS_n || k >= 40) begin
        done = 1'b1;
      end else begin
        f_mosi = {f_mosi[30:0], MOSI};
        if (cmd_ready) f_rdy_bad++;
        if (rsp_valid) f_rsp_n++;
        MISO = (k >= 13 && k <= 20) ? rx[20-k] : 1'b1;
        if (k == rst_at) rst = 1'b1;
        tick();
        rst = 1'b0;
        if (k == rst_at) done = 1'b1;
        k++;
      end
    end
    f_low = k;
    MISO = 1'b0;
    if (rst_at < 0) begin
      while (!cmd_ready && f_gap < 10) begin
        if (rsp_valid) begin
          f_rsp_n++;
          if (f_rsp_at < 0) f_rsp_at = k + f_gap;
        end
        f_gap++;
        tick();
      end
    end
  endtask

  logic [9:0] cmds [3];
  int frames, hi_run, min_gap, rdy_low, n_acc, rsp_seen;
  bit ssn_prev, acc;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; MISO = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ssn", SS_n, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_rspv", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rspd", rsp_data, 0);

    // write address 0x0A: START repeats bit 9, then bits 9..0
    run_frame(10'h00A, 8'h00, -1);
    check("wa_low", f_low, 11);
    check("wa_mosi", f_mosi, 32'h0000_000A);
    check("wa_rspn", f_rsp_n, 0);
    check("wa_rdy", f_rdy_bad, 0);
    check("wa_gap", f_gap, 1);

    run_frame(10'h1A5, 8'h00, -1);
    check("wd_low", f_low, 11);
    check("wd_mosi", f_mosi, 32'h0000_01A5);
    run_frame(10'h20A, 8'h00, -1);
    check("ra_low", f_low, 11);
    check("ra_mosi", f_mosi, 32'h0000_060A);
    check("ra_rspn", f_rsp_n, 0);
    run_frame(10'h300, 8'hA5, -1);
    check("rd_low", f_low, 21);
    check("rd_mosi", f_mosi, 32'h001C_0000);
    check("rd_rspn", f_rsp_n, 1);
    check("rd_rspat", f_rsp_at, 21);
    check("rd_data", rsp_data, 8'hA5);
    check("rd_gap", f_gap, 1);
    check("rd_rdy", f_rdy_bad, 0);

    run_frame(10'h0FF, 8'h00, -1);
    check("hold_mosi", f_mosi, 32'h0000_00FF);
    check("hold_data", rsp_data, 8'hA5);
    run_frame(10'h3FF, 8'h3C, -1);
    check("rd2_mosi", f_mosi, 32'h001F_FC00);
    check("rd2_data", rsp_data, 8'h3C);
    check("rd2_rspn", f_rsp_n, 1);

    // cmd_valid held high across three writes
    cmds[0] = 10'h011; cmds[1] = 10'h122; cmds[2] = 10'h033;
    frames = 0; hi_run = 0; min_gap = 99; rdy_low = 0; n_acc = 0; ssn_prev = 1'b1;
    cmd_valid = 1'b1; cmd_data = cmds[0];
    for (int c = 0; c < 80; c++) begin
      acc = cmd_valid && cmd_ready;
      if (!SS_n) begin
        if (ssn_prev) begin
          if (frames > 0 && hi_run < min_gap) min_gap = hi_run;
          frames++;
        end
        hi_run = 0;
        if (cmd_ready) rdy_low++;
      end else begin
        hi_run++;
      end
      ssn_prev = SS_n;
      tick();
      if (acc) begin
        n_acc++;
        if (n_acc == 3) cmd_valid = 1'b0;
        else cmd_data = cmds[n_acc];
      end
    end
    check("b2b_frames", frames, 3);
    check("b2b_acc", n_acc, 3);
    check("b2b_gap", min_gap, 2);
    check("b2b_rdy", rdy_low, 0);

    // reset during the 4th RECV bit
    run_frame(10'h3C3, 8'hFF, 16);
    check("ab_low", f_low, 17);
    check("ab_ssn", SS_n, 1);
    check("ab_rspv", rsp_valid, 0);
    check("ab_rspd", rsp_data, 0);
    check("ab_busy", busy, 0);
    check("ab_ready", cmd_ready, 1);
    rsp_seen = f_rsp_n;
    repeat (5) begin
      if (rsp_valid) rsp_seen++;
      tick();
    end
    check("ab_norsp", rsp_seen, 0);
    run_frame(10'h20A, 8'h00, -1);
    check("ab_next_low", f_low, 11);
    check("ab_next_mosi", f_mosi, 32'h0000_060A);

`ifdef SPI_MASTER_CNT_EN
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("cnt_rst", frame_cnt, 0);
    run_frame(10'h300, 8'h55, 16);
    for (int i = 0; i < 5; i++) run_frame(10'h040 + 10'(i), 8'h00, -1);
    check("cnt_five", frame_cnt, 5);
    dut.r_frame_cnt = 16'hFFFF;
    run_frame(10'h0AA, 8'h00, -1);
    check("cnt_wrap", frame_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
